// File: rtl/cr_mean_align.sv
// ---------------------------------------------------------------------------
// cr_mean_align
//
// Purpose:
//   Consumer side of the mean-Cr path. Each incoming Cr sample is held in an
//   alignment FIFO while its luma travels through the mean-Cr unit. Every
//   returned mean-Cr value is paired, in order and one-to-one, with the oldest
//   buffered Cr. The block outputs |Cr - mean_Cr| in 8.8 fixed point and flags
//   the pixel as a skin candidate when that deviation is within THRESH.
//
// Parameters:
//   DEPTH   alignment FIFO depth (power of two)
//   AW      FIFO address width, log2(DEPTH)
//   THRESH  largest |Cr - mean_Cr| (integer Cr units) that still sets skin_flag
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   cr / cr_valid    Cr sample, presented when its luma enters the mean-Cr unit
//   mean_cr_in       mean Cr, unsigned 16.8 fixed point
//   mean_cr_in_valid mean_cr_in qualifier, returned in pixel order
//   cr_out           Cr of the paired pixel
//   deviation        |Cr - mean_Cr|, 8.8 fixed point, saturated to 16'hFFFF
//   skin_flag        deviation <= THRESH<<8
//   out_valid        qualifies cr_out / deviation / skin_flag (one cycle per pop)
//   fifo_level       FIFO occupancy 0..DEPTH (registered)
//   overflow_err     sticky: cr_valid arrived while FIFO full and not draining
//   underflow_err    sticky: mean_cr_in_valid arrived while FIFO empty
//   skin_count       number of out_valid cycles with skin_flag set
//
// Configuration macro:
//   CR_MEAN_STATS_EN  when defined, skin_count is a saturating 32-bit counter;
//                     otherwise the counter is not built and skin_count is 0.
// ---------------------------------------------------------------------------
module cr_mean_align #(
  parameter int          DEPTH  = 64,
  parameter int          AW     = 6,
  parameter logic [15:0] THRESH = 16'd20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    cr,
  input  logic          cr_valid,
  input  logic [23:0]   mean_cr_in,
  input  logic          mean_cr_in_valid,
  output logic [7:0]    cr_out,
  output logic [15:0]   deviation,
  output logic          skin_flag,
  output logic          out_valid,
  output logic [AW:0]   fifo_level,
  output logic          overflow_err,
  output logic          underflow_err,
  output logic [31:0]   skin_count
);

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q,  level_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  logic fifo_full;
  logic fifo_empty;
  logic push_en;
  logic pop_en;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

  // No bypass path: a pop needs data that was already stored last cycle.
  // A push is still accepted on a full FIFO if the same cycle frees a slot.
  assign pop_en  = mean_cr_in_valid && !fifo_empty;
  assign push_en = cr_valid && (!fifo_full || pop_en);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (cr_valid && !push_en) begin
      overflow_d = 1'b1;
    end
    if (mean_cr_in_valid && fifo_empty) begin
      underflow_d = 1'b1;
    end

    level_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage: plain array with a registered read port so it maps onto
  // block RAM. The read register doubles as the S1 Cr register. When a full
  // FIFO pushes and pops in the same cycle both hit the same address; the
  // read returns the old entry, which is the one being popped.
  // -------------------------------------------------------------------------
  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_q[AW-1:0]] <= cr;
    end
    if (pop_en) begin
      rd_data_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: popped Cr (rd_data_q) and its mean, plus the signed difference.
  // -------------------------------------------------------------------------
  logic [23:0] s1_mean_q,  s1_mean_d;
  logic        s1_valid_q, s1_valid_d;

  always_comb begin
    s1_mean_d  = s1_mean_q;
    s1_valid_d = pop_en;
    if (pop_en) begin
      s1_mean_d = mean_cr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_mean_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_mean_q  <= s1_mean_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  // Cr is promoted to 16.8 and both operands are zero-extended to 25 bits so
  // the subtraction can never wrap.
  logic signed [24:0] diff;
  logic        [24:0] abs_diff;
  logic        [15:0] dev_sat;
  logic               skin_hit;

  always_comb begin
    diff     = $signed({9'b0, rd_data_q, 8'b0}) - $signed({1'b0, s1_mean_q});
    abs_diff = diff[24] ? 25'(-diff) : 25'(diff);
    dev_sat  = (|abs_diff[24:16]) ? 16'hFFFF : abs_diff[15:0];
    // Compare the unsaturated magnitude so a huge deviation can never alias
    // into the pass window.
    skin_hit = (abs_diff <= {1'b0, THRESH, 8'b0});
  end

  // -------------------------------------------------------------------------
  // Stage 2: output registers. Data outputs hold their last value between
  // valid cycles; out_valid pulses once per accepted pop.
  // -------------------------------------------------------------------------
  logic [7:0]  cr_out_q,    cr_out_d;
  logic [15:0] dev_q,       dev_d;
  logic        skin_q,      skin_d;
  logic        out_valid_q, out_valid_d;

  always_comb begin
    cr_out_d    = cr_out_q;
    dev_d       = dev_q;
    skin_d      = skin_q;
    out_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      cr_out_d = rd_data_q;
      dev_d    = dev_sat;
      skin_d   = skin_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cr_out_q    <= '0;
      dev_q       <= '0;
      skin_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cr_out_q    <= cr_out_d;
      dev_q       <= dev_d;
      skin_q      <= skin_d;
      out_valid_q <= out_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Optional skin-pixel statistics
  // -------------------------------------------------------------------------
`ifdef CR_MEAN_STATS_EN
  logic [31:0] skin_count_q, skin_count_d;

  always_comb begin
    skin_count_d = skin_count_q;
    // Saturate rather than wrap so a long run never reports a small count.
    if (out_valid_q && skin_q && (skin_count_q != 32'hFFFF_FFFF)) begin
      skin_count_d = skin_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skin_count_q <= '0;
    end else begin
      skin_count_q <= skin_count_d;
    end
  end

  assign skin_count = skin_count_q;
`else
  assign skin_count = '0;
`endif

  // -------------------------------------------------------------------------
  // Output assignments
  // -------------------------------------------------------------------------
  assign cr_out        = cr_out_q;
  assign deviation     = dev_q;
  assign skin_flag     = skin_q;
  assign out_valid     = out_valid_q;
  assign fifo_level    = level_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule
